mmu_weight_loader: RTL and testbench

- Transmit side of the MMU weight-shift interface.
- Collects one 16x16 int8 weight tile, row by row, from the weight buffer over a valid/ready stream into a local 16-row staging store.
- On request, drives the MMU `win`/`wen` inputs for exactly 16 consecutive cycles so that row 0 settles in PE row 0 and row 15 in PE row 15.
- Signals completion so the controller can start streaming activations.

---
 rtl/tpu_pkg.sv | 20 ++
 rtl/weight_stage_mem.sv | 40 ++++
 rtl/mmu_weight_loader.sv | 123 ++++++++++++
 tb/tb_mmu_weight_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU constants and types for the MMU weight path.
package tpu_pkg;

  localparam int unsigned MMU_ROWS = 16;
  localparam int unsigned MMU_COLS = 16;
  localparam int unsigned W_DW     = 8;
  localparam int unsigned ACC_DW   = 20;
  localparam int unsigned LDR_CW   = 5;
  localparam int unsigned ROW_W    = MMU_COLS * W_DW;

  // One weight row: lane j in bits [(j+1)*W_DW-1 : j*W_DW]
  typedef logic [ROW_W-1:0] w_row_t;

  typedef enum logic [1:0] {
    LDR_FILL  = 2'd0,
    LDR_READY = 2'd1,
    LDR_SHIFT = 2'd2
  } ldr_state_t;

endpackage

// File: rtl/weight_stage_mem.sv
// Staging register file for one weight tile: one write port, one registered read port.
// The read data is zero whenever no read is issued, so the output can drive the MMU directly.
module weight_stage_mem
  import tpu_pkg::*;
#(
  parameter int unsigned DEPTH = MMU_ROWS,
  parameter int unsigned WIDTH = ROW_W,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Row write; contents are not reset since stale rows are never read before refill
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read, forced to zero when idle or in reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/mmu_weight_loader.sv
// MMU weight loader: stages a ROWS x COLS tile from a valid/ready stream and
// shifts it into the MMU over ROWS consecutive wen cycles, row 0 first.
module mmu_weight_loader
  import tpu_pkg::*;
#(
  parameter int unsigned ROWS = MMU_ROWS,
  parameter int unsigned COLS = MMU_COLS,
  parameter int unsigned DW   = W_DW,
  parameter int unsigned CW   = LDR_CW
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 w_valid,
  input  logic [COLS*DW-1:0]   w_data,
  output logic                 w_ready,
  input  logic                 load_req,
  output logic [COLS*DW-1:0]   win,
  output logic                 wen,
  output logic                 full,
  output logic                 busy,
  output logic                 load_done
);

  localparam int unsigned AW       = $clog2(ROWS);
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);
  localparam logic [CW-1:0] END_CNT  = CW'(ROWS);

  ldr_state_t    state;
  logic [CW-1:0] fill_cnt;
  logic [CW-1:0] shift_cnt;
  logic          pending;
  logic          accept;
  logic          rd_en;

  // Handshake uses the registered ready, so no input reaches an output combinationally
  assign accept = w_valid & w_ready;

  // Reads run for shift counts 0..ROWS-1; count ROWS is the completion cycle
  assign rd_en = (state == LDR_SHIFT) && (shift_cnt != END_CNT);

  // Staging store; its registered read data is the win output
  weight_stage_mem #(
    .DEPTH (ROWS),
    .WIDTH (COLS * DW),
    .AW    (AW)
  ) u_stage (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (accept),
    .waddr   (fill_cnt[AW-1:0]),
    .wdata   (w_data),
    .re      (rd_en),
    .raddr   (shift_cnt[AW-1:0]),
    .rdata   (win)
  );

  // Loader FSM with counters and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= LDR_FILL;
      fill_cnt  <= '0;
      shift_cnt <= '0;
      pending   <= 1'b0;
      w_ready   <= 1'b0;
      wen       <= 1'b0;
      full      <= 1'b0;
      busy      <= 1'b0;
      load_done <= 1'b0;
    end else begin
      load_done <= 1'b0;

      // Requests outside a burst are remembered until the burst starts
      if (load_req && (state != LDR_SHIFT)) begin
        pending <= 1'b1;
      end

      case (state)
        LDR_FILL: begin
          w_ready <= 1'b1;
          if (accept) begin
            fill_cnt <= fill_cnt + CW'(1);
            if (fill_cnt == LAST_ROW) begin
              state   <= LDR_READY;
              full    <= 1'b1;
              w_ready <= 1'b0;
            end
          end
        end

        LDR_READY: begin
          if (pending || load_req) begin
            state     <= LDR_SHIFT;
            pending   <= 1'b0;
            busy      <= 1'b1;
            shift_cnt <= '0;
          end
        end

        LDR_SHIFT: begin
          if (shift_cnt == END_CNT) begin
            state     <= LDR_FILL;
            wen       <= 1'b0;
            busy      <= 1'b0;
            full      <= 1'b0;
            pending   <= 1'b0;
            fill_cnt  <= '0;
            shift_cnt <= '0;
            load_done <= 1'b1;
            w_ready   <= 1'b1;
          end else begin
            wen       <= 1'b1;
            shift_cnt <= shift_cnt + CW'(1);
          end
        end

        default: begin
          state <= LDR_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_weight_loader.sv
// Testbench for mmu_weight_loader: scenario table, hand-written corner sequences,
// and randomized traffic, all checked against a tile/burst-timeline reference model.
module tb_mmu_weight_loader;
  import tpu_pkg::*;

  localparam int unsigned RW = MMU_COLS * W_DW;
  typedef logic [RW-1:0] row_t;
  typedef row_t tile_t [MMU_ROWS];

  // sel: data pattern; req_at: accepted-row count at which a lone load_req pulse is sent
  // (16 = after full, after 'lag' idle cycles); req_last: load_req with the 16th row;
  // exp_gap: edges from the 16th accept to the first wen
  typedef struct {
    int sel;
    int req_at;
    int lag;
    bit req_last;
    bit toggle;
    bit req_in_shift;
    int exp_gap;
  } scen_t;

  logic       clk;
  logic       reset_n;
  logic       w_valid;
  row_t       w_data;
  logic       w_ready;
  logic       load_req;
  row_t       win;
  logic       wen;
  logic       full;
  logic       busy;
  logic       load_done;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_acc = 0;

  mmu_weight_loader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .w_valid   (w_valid),
    .w_data    (w_data),
    .w_ready   (w_ready),
    .load_req  (load_req),
    .win       (win),
    .wen       (wen),
    .full      (full),
    .busy      (busy),
    .load_done (load_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %b, expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input row_t act, input row_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the tile as a list of accepted rows and the burst as an age since it began.
  row_t m_tile [MMU_ROWS];
  int   m_rows = 0;
  int   m_age  = -1;
  bit   m_req  = 1'b0;
  bit   m_ready = 1'b0;
  bit   m_full = 1'b0;
  bit   m_done = 1'b0;
  logic e_wen;
  row_t e_win;

  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      m_rows = 0; m_age = -1; m_req = 1'b0;
      m_ready = 1'b0; m_full = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (load_req && m_age < 0) m_req = 1'b1;
      if (m_age >= 0) begin
        m_age++;
        if (m_age == MMU_ROWS + 1) begin
          m_age = -1; m_rows = 0; m_req = 1'b0;
          m_full = 1'b0; m_done = 1'b1; m_ready = 1'b1;
        end
      end else if (m_rows == MMU_ROWS) begin
        if (m_req) begin
          m_age = 0;
          m_req = 1'b0;
        end
      end else begin
        if (w_valid && m_ready) begin
          m_tile[m_rows] = w_data;
          m_rows++;
        end
        m_ready = (m_rows != MMU_ROWS);
        m_full  = (m_rows == MMU_ROWS);
      end
    end
    e_wen = (m_age >= 1) && (m_age <= MMU_ROWS);
    e_win = '0;
    if (e_wen) e_win = m_tile[m_age-1];
    #2;
    chkb("model_w_ready", w_ready, m_ready);
    chkb("model_wen", wen, e_wen);
    chkw("model_win", win, e_win);
    chkb("model_full", full, m_full);
    chkb("model_busy", busy, m_age >= 0);
    chkb("model_load_done", load_done, m_done);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic row_t make_row(input int sel, input int r);
    row_t x;
    x = '0;
    for (int j = 0; j < MMU_COLS; j++) begin
      case (sel)
        0:       x[j*W_DW +: W_DW] = 8'(r + 1);
        1:       x[j*W_DW +: W_DW] = 8'(8'h80 | j);
        default: x[j*W_DW +: W_DW] = 8'($urandom);
      endcase
    end
    return x;
  endfunction

  // Present a row and hold it until accepted; optionally idle one cycle afterwards
  task automatic send_row(input row_t d, input bit toggle);
    bit acc;
    bit ok;
    ok = 1'b0;
    w_valid = 1'b1;
    w_data  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      acc = w_ready;
      tick();
      if (acc) ok = 1'b1;
    end
    load_req = 1'b0;
    chkb("row_accept", ok, 1'b1);
    last_acc = cyc;
    if (toggle) begin
      w_valid = 1'b0;
      tick();
    end
  endtask

  task automatic pulse_req();
    w_valid  = 1'b0;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  // Wait for a burst, check its 16 rows, then step into the load_done cycle
  task automatic wait_burst(input tile_t t, input bit poke, output int first);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (wen) got = 1'b1;
    end
    chkb("burst_start", got, 1'b1);
    first = cyc;
    if (got) begin
      for (int k = 0; k < MMU_ROWS; k++) begin
        chkb("burst_wen", wen, 1'b1);
        chkw("burst_win", win, t[k]);
        chkb("burst_w_ready", w_ready, 1'b0);
        chkb("burst_busy", busy, 1'b1);
        if (poke) load_req = (k == 5);
        if (k < MMU_ROWS - 1) tick();
      end
    end
    load_req = 1'b0;
    tick();
    chkb("done_pulse", load_done, 1'b1);
    chkb("done_wen", wen, 1'b0);
    chkw("done_win", win, '0);
    chkb("done_full", full, 1'b0);
    chkb("done_w_ready", w_ready, 1'b1);
  endtask

  task automatic run_scen(input scen_t s);
    tile_t t;
    int a;
    int first;
    for (int r = 0; r < MMU_ROWS; r++) t[r] = make_row(s.sel, r);
    for (int r = 0; r < MMU_ROWS; r++) begin
      if (!s.req_last && s.req_at == r) pulse_req();
      if (s.req_last && r == MMU_ROWS - 1) load_req = 1'b1;
      send_row(t[r], s.toggle);
    end
    a = last_acc;
    w_valid = 1'b0;
    chkb("scen_full", full, 1'b1);
    chkb("scen_ready_low", w_ready, 1'b0);
    if (!s.req_last && s.req_at == MMU_ROWS) begin
      repeat (s.lag) tick();
      pulse_req();
    end
    wait_burst(t, s.req_in_shift, first);
    chki("scen_gap", first - a, s.exp_gap);
  endtask

  // ---------------- main sequence ----------------
  scen_t tbl [6];

  initial begin
    tile_t t1;
    tile_t t2;
    int    first;
    int    done_edge;
    bit    got;

    tbl[0] = '{0, 16, 1, 1'b0, 1'b0, 1'b0, 3};
    tbl[1] = '{1,  5, 0, 1'b0, 1'b1, 1'b0, 2};
    tbl[2] = '{2, -1, 0, 1'b1, 1'b0, 1'b0, 2};
    tbl[3] = '{2, 16, 4, 1'b0, 1'b0, 1'b0, 6};
    tbl[4] = '{2,  0, 0, 1'b0, 1'b0, 1'b0, 2};
    tbl[5] = '{0, 16, 0, 1'b0, 1'b0, 1'b1, 2};

    reset_n  = 1'b0;
    w_valid  = 1'b0;
    w_data   = '0;
    load_req = 1'b0;

    // Reset, then idle
    repeat (3) tick();
    chkb("rst_w_ready", w_ready, 1'b0);
    chkb("rst_wen", wen, 1'b0);
    chkw("rst_win", win, '0);
    reset_n = 1'b1;
    tick();
    chkb("post_rst_w_ready", w_ready, 1'b1);
    chkb("post_rst_full", full, 1'b0);
    chkb("post_rst_busy", busy, 1'b0);
    chkb("post_rst_done", load_done, 1'b0);
    repeat (3) tick();

    // Scenario table
    for (int i = 0; i < 6; i++) run_scen(tbl[i]);

    // The request poked mid-burst above must not start a second burst
    for (int r = 0; r < MMU_ROWS; r++) t1[r] = make_row(0, r);
    for (int r = 0; r < MMU_ROWS; r++) send_row(t1[r], 1'b0);
    w_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chkb("no_requeue_wen", wen, 1'b0);
    end
    chkb("no_requeue_full", full, 1'b1);
    pulse_req();
    wait_burst(t1, 1'b0, first);

    // Reset in the middle of a burst
    for (int r = 0; r < MMU_ROWS; r++) t1[r] = make_row(2, r);
    for (int r = 0; r < MMU_ROWS; r++) send_row(t1[r], 1'b0);
    pulse_req();
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (wen) got = 1'b1;
    end
    chkb("midrst_burst_start", got, 1'b1);
    repeat (6) tick();
    reset_n = 1'b0;
    tick();
    chkb("midrst_wen", wen, 1'b0);
    chkb("midrst_busy", busy, 1'b0);
    chkb("midrst_full", full, 1'b0);
    chkw("midrst_win", win, '0);
    reset_n = 1'b1;
    tick();
    for (int r = 0; r < MMU_ROWS; r++) t1[r] = make_row(0, r);
    for (int r = 0; r < MMU_ROWS - 1; r++) send_row(t1[r], 1'b0);
    chkb("midrst_full_15", full, 1'b0);
    send_row(t1[MMU_ROWS-1], 1'b0);
    chkb("midrst_full_16", full, 1'b1);
    pulse_req();
    wait_burst(t1, 1'b0, first);

    // Back-to-back tiles with w_valid held high
    for (int r = 0; r < MMU_ROWS; r++) t1[r] = make_row(2, r);
    for (int r = 0; r < MMU_ROWS; r++) t2[r] = make_row(1, r);
    for (int r = 0; r < MMU_ROWS; r++) begin
      if (r == MMU_ROWS - 1) load_req = 1'b1;
      send_row(t1[r], 1'b0);
    end
    w_data = t2[0];
    wait_burst(t1, 1'b0, first);
    done_edge = cyc;
    for (int r = 0; r < MMU_ROWS; r++) begin
      send_row(t2[r], 1'b0);
      if (r == 0) chki("b2b_first_accept", last_acc, done_edge + 1);
    end
    w_valid = 1'b0;
    pulse_req();
    wait_burst(t2, 1'b0, first);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      reset_n  = ($urandom_range(0, 999) >= 3);
      w_valid  = ($urandom_range(0, 9) < 7);
      w_data   = {$urandom, $urandom, $urandom, $urandom};
      load_req = ($urandom_range(0, 19) == 0);
      tick();
    end
    reset_n  = 1'b1;
    w_valid  = 1'b0;
    load_req = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
